// File: rtl/draw_racket_ctl_if.sv
// VGA stream bundle: timing counters, sync/blank strobes and pixel colour.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_racket_ctl.sv
// Two-racket overlay for the 65 MHz VGA pipeline. Racket positions are
// clamped, rate-limited and only updated on vblnk entry so a frame is never
// drawn with a racket that moved half-way down the screen.
module draw_racket_ctl #(
    parameter logic [10:0] X_P1     = 11'd32,
    parameter logic [10:0] X_P2     = 11'd976,
    parameter logic [10:0] WIDTH    = 11'd16,
    parameter logic [9:0]  HEIGHT   = 10'd80,
    parameter logic [9:0]  Y_MIN    = 10'd51,
    parameter logic [9:0]  Y_MAX    = 10'd717,
    parameter logic [9:0]  MAX_STEP = 10'd16,
    parameter logic [10:0] V_RES    = 11'd768,
    parameter logic [11:0] COLOR    = 12'hFFF
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic [11:0] mouse_ypos,
    input  logic [9:0]  input_pos,
    input  logic        screen_idle,
    input  logic        screen_single,
    output logic [9:0]  output_pos,
    output logic [9:0]  pos_p2,
    vga_if.in           draw_bg_if,
    vga_if.out          draw_rect_if
);

    localparam logic signed [12:0] Y_LO_S   = 13'(Y_MIN);
    localparam logic signed [12:0] Y_HI_S   = 13'(Y_MAX) - 13'(HEIGHT);
    localparam logic signed [12:0] STEP_S   = 13'(MAX_STEP);
    localparam logic signed [12:0] MIRROR_S = 13'(V_RES) - 13'(HEIGHT);
    localparam logic [9:0]         CENTRE   = 10'((13'(Y_MIN) + 13'(Y_MAX) - 13'(HEIGHT)) >> 1);

    typedef enum logic [1:0] {MODE_MULTI, MODE_SINGLE, MODE_IDLE} mode_e;

    // Limit a signed candidate position to the playfield.
    function automatic logic [9:0] clamp_pos(input logic signed [12:0] v);
        logic signed [12:0] r;
        if (v < Y_LO_S)      r = Y_LO_S;
        else if (v > Y_HI_S) r = Y_HI_S;
        else                 r = v;
        return r[9:0];
    endfunction

    // Move pos towards tgt by at most MAX_STEP (MAX_STEP of 0 jumps straight there).
    function automatic logic [9:0] step_pos(input logic [9:0] pos, input logic [9:0] tgt);
        logic signed [12:0] diff;
        logic signed [12:0] mag;
        logic signed [12:0] nxt;
        diff = $signed({3'b000, tgt}) - $signed({3'b000, pos});
        mag  = (diff < 13'sd0) ? -diff : diff;
        if (MAX_STEP == 10'd0 || mag <= STEP_S) nxt = $signed({3'b000, tgt});
        else if (diff > 13'sd0)                 nxt = $signed({3'b000, pos}) + STEP_S;
        else                                    nxt = $signed({3'b000, pos}) - STEP_S;
        return clamp_pos(nxt);
    endfunction

    // Strict-bound rectangle test for one racket.
    function automatic logic in_racket(input logic [10:0] h, input logic [10:0] v,
                                       input logic [10:0] x, input logic [9:0] pos);
        logic [11:0] x1;
        logic [11:0] y0;
        logic [11:0] y1;
        x1 = {1'b0, x} + {1'b0, WIDTH};
        y0 = {2'b00, pos};
        y1 = {2'b00, pos} + {2'b00, HEIGHT};
        return ({1'b0, h} > {1'b0, x}) && ({1'b0, h} < x1) &&
               ({1'b0, v} > y0) && ({1'b0, v} < y1);
    endfunction

    mode_e       mode_q, mode_d;
    logic        vblnk_prev_q;
    logic        upd;
    logic [9:0]  pos1_q, pos1_d;
    logic [9:0]  pos2_q, pos2_d;
    logic [9:0]  t1, t2;
    logic [11:0] rgb_d;

    assign upd = draw_bg_if.vblnk & ~vblnk_prev_q;

    // Mode latch, vblnk edge detector and racket positions.
    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_MULTI;
            vblnk_prev_q <= 1'b0;
            pos1_q       <= CENTRE;
            pos2_q       <= CENTRE;
        end else begin
            mode_q       <= mode_d;
            vblnk_prev_q <= draw_bg_if.vblnk;
            pos1_q       <= pos1_d;
            pos2_q       <= pos2_d;
        end
    end

    // Next mode: screen flags are sampled only at a frame update, idle winning over single.
    always_comb begin
        mode_d = mode_q;
        if (upd) begin
            if (screen_idle)        mode_d = MODE_IDLE;
            else if (screen_single) mode_d = MODE_SINGLE;
            else                    mode_d = MODE_MULTI;
        end
    end

    // Targets for the incoming mode and the rate-limited step towards them.
    always_comb begin
        t1     = clamp_pos($signed({1'b0, mouse_ypos}));
        t2     = clamp_pos($signed({3'b000, input_pos}));
        pos1_d = pos1_q;
        pos2_d = pos2_q;
        if (mode_d == MODE_SINGLE) begin
            t2 = clamp_pos(MIRROR_S - $signed({3'b000, t1}));
        end else if (mode_d == MODE_IDLE) begin
            t1 = CENTRE;
            t2 = CENTRE;
        end
        if (upd) begin
            pos1_d = step_pos(pos1_q, t1);
            pos2_d = step_pos(pos2_q, t2);
        end
    end

    // Pixel colour from the undelayed stream and the current positions.
    always_comb begin
        rgb_d = draw_bg_if.rgb;
        if (mode_q != MODE_IDLE &&
            (in_racket(draw_bg_if.hcount, draw_bg_if.vcount, X_P1, pos1_q) ||
             in_racket(draw_bg_if.hcount, draw_bg_if.vcount, X_P2, pos2_q))) begin
            rgb_d = COLOR;
        end
    end

    // One-clock output stage for the video stream and the position copies.
    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            draw_rect_if.vcount <= '0;
            draw_rect_if.vsync  <= 1'b0;
            draw_rect_if.vblnk  <= 1'b0;
            draw_rect_if.hcount <= '0;
            draw_rect_if.hsync  <= 1'b0;
            draw_rect_if.hblnk  <= 1'b0;
            draw_rect_if.rgb    <= '0;
            output_pos          <= CENTRE;
            pos_p2              <= CENTRE;
        end else begin
            draw_rect_if.vcount <= draw_bg_if.vcount;
            draw_rect_if.vsync  <= draw_bg_if.vsync;
            draw_rect_if.vblnk  <= draw_bg_if.vblnk;
            draw_rect_if.hcount <= draw_bg_if.hcount;
            draw_rect_if.hsync  <= draw_bg_if.hsync;
            draw_rect_if.hblnk  <= draw_bg_if.hblnk;
            draw_rect_if.rgb    <= rgb_d;
            output_pos          <= pos1_q;
            pos_p2              <= pos2_q;
        end
    end

endmodule

// File: tb/tb_draw_racket_ctl.sv
// Bench for draw_racket_ctl: one instance with the default step limit and one
// with MAX_STEP=0, both fed the same stream and checked against a frame-level model.
module tb_draw_racket_ctl;

    localparam int X1 = 32, X2 = 976, W = 16, H = 80;
    localparam int YLO = 51, YHI = 637, CENTRE = 344, VRES = 768;
    localparam int COLOR = 'hFFF;

    logic        clk65MHz = 1'b0;
    logic        rst;
    logic [11:0] mouse_ypos;
    logic [9:0]  input_pos;
    logic        screen_idle;
    logic        screen_single;
    logic [9:0]  out_pos0, p2_0, out_pos1, p2_1;

    vga_if bg();
    vga_if rc0();
    vga_if rc1();

    always #5 clk65MHz = ~clk65MHz;

    draw_racket_ctl dut0 (
        .clk65MHz(clk65MHz), .rst(rst), .mouse_ypos(mouse_ypos), .input_pos(input_pos),
        .screen_idle(screen_idle), .screen_single(screen_single),
        .output_pos(out_pos0), .pos_p2(p2_0), .draw_bg_if(bg), .draw_rect_if(rc0)
    );

    draw_racket_ctl #(.MAX_STEP(10'd0)) dut1 (
        .clk65MHz(clk65MHz), .rst(rst), .mouse_ypos(mouse_ypos), .input_pos(input_pos),
        .screen_idle(screen_idle), .screen_single(screen_single),
        .output_pos(out_pos1), .pos_p2(p2_1), .draw_bg_if(bg), .draw_rect_if(rc1)
    );

    int n_vec = 0;
    int n_err = 0;

    // model state: mode 0=multi 1=single 2=idle; index 0 -> dut0, 1 -> dut1
    int m_prev, m_mode;
    int mp1[2], mp2[2];
    int ms[2] = '{16, 0};
    int edges[8] = '{32, 33, 47, 48, 976, 977, 991, 992};

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < YLO) return YLO;
        if (v > YHI) return YHI;
        return v;
    endfunction

    function automatic int stepi(input int p, input int t, input int m);
        int d;
        d = t - p;
        if (m == 0 || (d < 0 ? -d : d) <= m) return t;
        return (d > 0) ? p + m : p - m;
    endfunction

    function automatic bit hiti(input int h, input int v, input int p1, input int p2);
        return (h > X1 && h < X1 + W && v > p1 && v < p1 + H) ||
               (h > X2 && h < X2 + W && v > p2 && v < p2 + H);
    endfunction

    function automatic int pack_tim(input logic [10:0] vc, input logic vs, input logic vb,
                                    input logic [10:0] hc, input logic hs, input logic hb);
        return int'({vc, vs, vb, hc, hs, hb});
    endfunction

    task automatic model_reset();
        m_prev = 0;
        m_mode = 0;
        for (int k = 0; k < 2; k++) begin
            mp1[k] = CENTRE;
            mp2[k] = CENTRE;
        end
    endtask

    // One clock: predict from current inputs, advance the model, then compare.
    task automatic cycle();
        int e_rgb[2], e_op[2], e_p2[2];
        int e_tim, h, v, nm, t1, t2;
        h = int'(bg.hcount);
        v = int'(bg.vcount);
        e_tim = pack_tim(bg.vcount, bg.vsync, bg.vblnk, bg.hcount, bg.hsync, bg.hblnk);
        for (int k = 0; k < 2; k++) begin
            e_rgb[k] = (m_mode != 2 && hiti(h, v, mp1[k], mp2[k])) ? COLOR : int'(bg.rgb);
            e_op[k]  = mp1[k];
            e_p2[k]  = mp2[k];
        end
        if (bg.vblnk && m_prev == 0) begin
            nm = screen_idle ? 2 : (screen_single ? 1 : 0);
            t1 = clampi(int'(mouse_ypos));
            t2 = clampi(int'(input_pos));
            if (nm == 1) t2 = clampi(VRES - H - t1);
            if (nm == 2) begin t1 = CENTRE; t2 = CENTRE; end
            for (int k = 0; k < 2; k++) begin
                mp1[k] = stepi(mp1[k], t1, ms[k]);
                mp2[k] = stepi(mp2[k], t2, ms[k]);
            end
            m_mode = nm;
        end
        m_prev = bg.vblnk ? 1 : 0;
        @(posedge clk65MHz);
        #1;
        chk("tim0", pack_tim(rc0.vcount, rc0.vsync, rc0.vblnk, rc0.hcount, rc0.hsync, rc0.hblnk), e_tim);
        chk("tim1", pack_tim(rc1.vcount, rc1.vsync, rc1.vblnk, rc1.hcount, rc1.hsync, rc1.hblnk), e_tim);
        chk("rgb0", int'(rc0.rgb), e_rgb[0]);
        chk("rgb1", int'(rc1.rgb), e_rgb[1]);
        chk("opos0", int'(out_pos0), e_op[0]);
        chk("opos1", int'(out_pos1), e_op[1]);
        chk("pos_p2_0", int'(p2_0), e_p2[0]);
        chk("pos_p2_1", int'(p2_1), e_p2[1]);
    endtask

    // Asynchronous reset landing between clock edges.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_tim0", pack_tim(rc0.vcount, rc0.vsync, rc0.vblnk, rc0.hcount, rc0.hsync, rc0.hblnk), 0);
        chk("rst_tim1", pack_tim(rc1.vcount, rc1.vsync, rc1.vblnk, rc1.hcount, rc1.hsync, rc1.hblnk), 0);
        chk("rst_rgb0", int'(rc0.rgb), 0);
        chk("rst_rgb1", int'(rc1.rgb), 0);
        chk("rst_opos0", int'(out_pos0), CENTRE);
        chk("rst_pp2_0", int'(p2_0), CENTRE);
        chk("rst_opos1", int'(out_pos1), CENTRE);
        chk("rst_pp2_1", int'(p2_1), CENTRE);
        model_reset();
        @(posedge clk65MHz);
        #1 rst = 1'b0;
    endtask

    task automatic set_pix(input int h, input int v, input logic vb, input logic [11:0] c);
        bg.hcount = 11'(h);
        bg.vcount = 11'(v);
        bg.vblnk  = vb;
        bg.vsync  = 1'b0;
        bg.hsync  = 1'b0;
        bg.hblnk  = 1'b0;
        bg.rgb    = c;
    endtask

    task automatic rand_pix(input logic vb);
        int h, v, r, base;
        r = int'($urandom_range(0, 3));
        case (r)
            0:       h = int'($urandom_range(25, 55));
            1:       h = int'($urandom_range(965, 1000));
            2:       h = edges[$urandom_range(0, 7)];
            default: h = int'($urandom_range(0, 1343));
        endcase
        r = int'($urandom_range(0, 3));
        if (r == 0)      v = int'($urandom_range(0, 805));
        else if (r == 3) v = int'($urandom_range(700, 730));
        else begin
            base = (r == 1) ? mp1[0] : mp2[0];
            if ($urandom_range(0, 1) == 1) base += H;
            v = base + int'($urandom_range(0, 2)) - 1;
        end
        bg.hcount = 11'(h);
        bg.vcount = 11'(v);
        bg.vblnk  = vb;
        bg.vsync  = 1'($urandom_range(0, 1));
        bg.hsync  = 1'($urandom_range(0, 1));
        bg.hblnk  = 1'($urandom_range(0, 1));
        bg.rgb    = 12'($urandom);
    endtask

    task automatic frame(input int n, input bit toggle, input bit rst_ok);
        for (int i = 0; i < n; i++) begin
            if (toggle && i == n / 2) begin
                screen_idle   = 1'($urandom_range(0, 1));
                screen_single = 1'($urandom_range(0, 1));
            end
            if (rst_ok && i == n / 2 && $urandom_range(0, 19) == 0) do_reset();
            rand_pix(1'b0);
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            rand_pix(1'b1);
            cycle();
        end
    endtask

    task automatic frames(input int cnt);
        for (int f = 0; f < cnt; f++) frame(8, 1'b0, 1'b0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        mouse_ypos = 12'd344;
        input_pos = 10'd344;
        screen_idle = 1'b0;
        screen_single = 1'b0;
        set_pix(0, 0, 1'b0, 12'h000);
        model_reset();
        @(posedge clk65MHz);
        #1;
        chk("init_rgb0", int'(rc0.rgb), 0);
        chk("init_tim0", pack_tim(rc0.vcount, rc0.vsync, rc0.vblnk, rc0.hcount, rc0.hsync, rc0.hblnk), 0);
        chk("init_opos0", int'(out_pos0), CENTRE);
        chk("init_pp2_0", int'(p2_0), CENTRE);
        rst = 1'b0;

        // racket pixel at centre position, then the strict left edge
        set_pix(40, 400, 1'b0, 12'h123);
        cycle();
        chk("hit_40_400", int'(rc0.rgb), 'hFFF);
        set_pix(32, 400, 1'b0, 12'h123);
        cycle();
        chk("edge_32", int'(rc0.rgb), 'h123);

        // rate-limited travel 344 -> 500
        mouse_ypos = 12'd500;
        frames(1);
        chk("step_first", int'(out_pos0), 360);
        chk("jump_first", int'(out_pos1), 500);
        frames(8);
        chk("step_ninth", int'(out_pos0), 488);
        frames(1);
        chk("step_tenth", int'(out_pos0), 500);

        // clamping, high and low
        mouse_ypos = 12'd2000;
        input_pos = 10'd1023;
        frames(40);
        chk("clamp_hi_p1", int'(out_pos0), 637);
        chk("clamp_hi_p2", int'(p2_0), 637);
        mouse_ypos = 12'd10;
        input_pos = 10'd0;
        frames(40);
        chk("clamp_lo_p1", int'(out_pos0), 51);
        chk("clamp_lo_p2", int'(p2_0), 51);

        // single player mirroring
        mouse_ypos = 12'd100;
        frames(6);
        screen_single = 1'b1;
        frames(40);
        chk("single_p1", int'(out_pos0), 100);
        chk("single_p2", int'(p2_0), 588);
        set_pix(980, 600, 1'b0, 12'h0A5);
        cycle();
        chk("single_pix", int'(rc0.rgb), 'hFFF);

        // idle requested mid-frame takes effect only at vblnk
        for (int i = 0; i < 4; i++) begin rand_pix(1'b0); cycle(); end
        screen_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin rand_pix(1'b0); cycle(); end
        set_pix(40, 120, 1'b0, 12'h321);
        cycle();
        chk("idle_pending_pix", int'(rc0.rgb), 'hFFF);
        chk("idle_pending_pos", int'(out_pos0), 100);
        frames(40);
        chk("idle_p1", int'(out_pos0), CENTRE);
        chk("idle_p2", int'(p2_0), CENTRE);
        set_pix(40, 400, 1'b0, 12'h321);
        cycle();
        chk("idle_pix", int'(rc0.rgb), 'h321);

        // reset mid-frame from position 600
        screen_idle = 1'b0;
        screen_single = 1'b0;
        mouse_ypos = 12'd600;
        frames(30);
        chk("pre_rst_p1", int'(out_pos0), 600);
        for (int i = 0; i < 3; i++) begin rand_pix(1'b0); cycle(); end
        do_reset();
        frames(1);
        chk("post_rst_step", int'(out_pos0), 360);
        chk("post_rst_jump", int'(out_pos1), 600);

        // randomized requests, modes, mid-frame toggles and resets
        for (int f = 0; f < 150; f++) begin
            case ($urandom_range(0, 9))
                0:       mouse_ypos = 12'd0;
                1:       mouse_ypos = 12'd4095;
                2:       mouse_ypos = 12'd2000;
                3:       mouse_ypos = 12'd1023;
                default: mouse_ypos = 12'($urandom_range(0, 800));
            endcase
            case ($urandom_range(0, 5))
                0:       input_pos = 10'd0;
                1:       input_pos = 10'd1023;
                default: input_pos = 10'($urandom_range(0, 800));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                screen_idle   = 1'($urandom_range(0, 1));
                screen_single = 1'($urandom_range(0, 1));
            end
            frame(int'($urandom_range(4, 12)), 1'($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
